// File: rtl/spi_sd_responder.sv
// -----------------------------------------------------------------------------
// spi_sd_responder
//
// SPI mode-0 responder for the SD/MMC SPI link. Bytes from the master arrive on
// mosi, are assembled MSB first and handed to the local side on q. Reply bytes
// queued through d/txLoad are shifted out on miso, MSB first. When no reply is
// queued, the responder sends IDLE.
//
// The SPI pins are asynchronous to clock. They are oversampled through a
// two-flop synchroniser that advances only on ce ticks. Each SPI clock phase
// must therefore last at least three ce ticks.
//
// Ports
//   clock    in   1  system clock
//   reset    in   1  asynchronous, active-low reset
//   ce       in   1  sampling enable; all state advances only when ce=1
//   cs       in   1  SPI chip select, active low (asynchronous)
//   ck       in   1  SPI clock, idle low (asynchronous)
//   mosi     in   1  SPI data from master
//   miso     out  1  SPI data to master
//   d        in   8  reply byte to queue
//   txLoad   in   1  queue d (one ce tick)
//   txFull   out  1  reply buffer occupied
//   q        out  8  last received byte
//   rxValid  out  1  q holds an unacknowledged byte
//   rxAck    in   1  acknowledge q (one ce tick)
//   ovr      out  1  sticky overrun flag
//
// Local handshakes (all sampled on ce ticks):
//   tx side : txLoad is honoured only while txFull=0 or on the tick the buffer
//             drains into the shifter. txFull acts as the inverted ready.
//   rx side : rxValid is the valid flag for q and rxAck is the consume strobe.
//             A byte that completes while rxValid=1 and without rxAck is
//             dropped and sets ovr.
// -----------------------------------------------------------------------------
module spi_sd_responder #(
  parameter logic [7:0] IDLE = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       cs,
  input  logic       ck,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] d,
  input  logic       txLoad,
  output logic       txFull,
  output logic [7:0] q,
  output logic       rxValid,
  input  logic       rxAck,
  output logic       ovr
);

  // Synchroniser stages. The third cs/ck stage holds the previous synchronised
  // value, which is used for edge detection.
  logic cs_s1, cs_s2, cs_s3;
  logic ck_s1, ck_s2, ck_s3;
  logic mosi_s1, mosi_s2;

  logic [2:0] bit_cnt;
  logic [7:0] rx_sh;
  logic [7:0] tx_sh;
  logic [7:0] tx_buf;

  logic       active;
  logic       cs_fall;
  logic       ck_rise;
  logic       ck_fall;
  logic       byte_done;
  logic       tx_reload;
  logic [7:0] rx_byte;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
      ck_s1   <= 1'b0;
      ck_s2   <= 1'b0;
      ck_s3   <= 1'b0;
      mosi_s1 <= 1'b1;
      mosi_s2 <= 1'b1;
    end else if (ce) begin
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      ck_s1   <= ck;
      ck_s2   <= ck_s1;
      ck_s3   <= ck_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign active  = ~cs_s2;
  assign cs_fall = cs_s3 & ~cs_s2;
  assign ck_rise = active & ck_s2 & ~ck_s3;
  assign ck_fall = active & ~ck_s2 & ck_s3;

  // mosi travels through the same number of stages as ck, so the synchronised
  // mosi is already aligned with the synchronised rising edge.
  assign rx_byte   = {rx_sh[6:0], mosi_s2};
  assign byte_done = ck_rise & (bit_cnt == 3'd7);

  // The shifter reloads at the start of a frame and on the falling edge that
  // follows the eighth bit. At that point the counter has already wrapped to 0.
  assign tx_reload = cs_fall | (ck_fall & (bit_cnt == 3'd0));

  // miso is forced high while deselected. The shifter itself is also parked
  // at IDLE while deselected, so no stale bit is shown when cs falls.
  assign miso = active ? tx_sh[7] : 1'b1;

  // Bit counter and receive shifter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt <= 3'd0;
      rx_sh   <= IDLE;
    end else if (ce) begin
      if (!active) begin
        bit_cnt <= 3'd0;
      end else if (ck_rise) begin
        rx_sh   <= rx_byte;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Receive holding register and flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q       <= 8'h00;
      rxValid <= 1'b0;
      ovr     <= 1'b0;
    end else if (ce) begin
      if (byte_done) begin
        if (!rxValid || rxAck) begin
          // A same-tick acknowledge frees q for the byte completing now.
          q       <= rx_byte;
          rxValid <= 1'b1;
          if (rxAck) begin
            ovr <= 1'b0;
          end
        end else begin
          ovr <= 1'b1;
        end
      end else if (rxAck) begin
        rxValid <= 1'b0;
        ovr     <= 1'b0;
      end
    end
  end

  // Transmit shifter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_sh <= IDLE;
    end else if (ce) begin
      if (!active) begin
        tx_sh <= IDLE;
      end else if (tx_reload) begin
        tx_sh <= txFull ? tx_buf : IDLE;
      end else if (ck_fall) begin
        tx_sh <= {tx_sh[6:0], 1'b1};
      end
    end
  end

  // Reply buffer. When the buffer drains into the shifter on the same tick
  // that a new byte is offered, the new byte is accepted and the buffer stays
  // full.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_buf <= 8'h00;
      txFull <= 1'b0;
    end else if (ce) begin
      if (tx_reload && txFull) begin
        if (txLoad) begin
          tx_buf <= d;
        end else begin
          txFull <= 1'b0;
        end
      end else if (txLoad && !txFull) begin
        tx_buf <= d;
        txFull <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_sd_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_sd_responder
//
// Bench for spi_sd_responder. A pin-level SPI master drives random-length ck
// phases under a random ce pattern. A byte-level model tracks what the
// responder must report:
//   - which byte is being sent
//   - which bit is on miso
//   - the reply buffer
//   - q, rxValid and ovr
// Expected reply bytes wait in exp_q. A compare process checks every output
// once the pins have been stable for three ce ticks.
// -----------------------------------------------------------------------------
module tb_spi_sd_responder;

  // ---------------------------------------------------------------------------
  // Clock, reset and DUT
  // ---------------------------------------------------------------------------
  logic       clock  = 1'b0;
  logic       reset  = 1'b0;
  logic       ce     = 1'b0;
  logic       cs     = 1'b1;
  logic       ck     = 1'b0;
  logic       mosi   = 1'b1;
  logic       miso;
  logic [7:0] d      = 8'h00;
  logic       txLoad = 1'b0;
  logic       txFull;
  logic [7:0] q;
  logic       rxValid;
  logic       rxAck  = 1'b0;
  logic       ovr;

  spi_sd_responder dut (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .cs      (cs),
    .ck      (ck),
    .mosi    (mosi),
    .miso    (miso),
    .d       (d),
    .txLoad  (txLoad),
    .txFull  (txFull),
    .q       (q),
    .rxValid (rxValid),
    .rxAck   (rxAck),
    .ovr     (ovr)
  );

  initial forever #5 clock = ~clock;

  // ce is asserted on about three clock cycles in four.
  initial forever begin
    @(negedge clock);
    ce = ($urandom_range(0, 3) != 0);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helpers
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];          // reply bytes the master should see, in order
  bit         m_cs    = 1'b1;
  logic [7:0] m_tx    = 8'hFF;   // byte currently on the wire
  int         m_bit   = 7;       // bit of m_tx currently on miso
  logic [7:0] m_buf   = 8'h00;
  bit         m_full  = 1'b0;
  logic [7:0] m_q     = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_ovr   = 1'b0;
  logic [7:0] m_rx    = 8'h00;
  int         m_cnt   = 0;       // bits received in the current byte

  function automatic void model_reset();
    m_cs = 1'b1; m_tx = 8'hFF; m_bit = 7; m_buf = 8'h00; m_full = 1'b0;
    m_q = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_rx = 8'h00; m_cnt = 0;
    exp_q.delete();
  endfunction

  function automatic void model_next_byte();
    if (m_full) begin
      m_tx   = m_buf;
      m_full = 1'b0;
    end else begin
      m_tx = 8'hFF;
    end
    m_bit = 7;
    exp_q.push_back(m_tx);
  endfunction

  function automatic void model_cs_fall();
    m_cs  = 1'b0;
    m_cnt = 0;
    model_next_byte();
  endfunction

  function automatic void model_cs_rise();
    m_cs  = 1'b1;
    m_cnt = 0;
    exp_q.delete();              // a byte loaded but never clocked out is lost
  endfunction

  function automatic void model_rise(input logic b, input bit ack_same);
    m_rx  = {m_rx[6:0], b};
    m_cnt = m_cnt + 1;
    if (m_cnt == 8) begin
      m_cnt = 0;
      if (!m_valid || ack_same) begin
        m_q     = m_rx;
        m_valid = 1'b1;
        m_ovr   = 1'b0;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endfunction

  function automatic void model_fall();
    if (m_cnt == 0) model_next_byte();
    else m_bit = m_bit - 1;
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process: outputs are meaningful once cs/ck have been stable for
  // three ce ticks, since the synchroniser latency is three ticks.
  // ---------------------------------------------------------------------------
  int         settle = 0;
  logic [1:0] snap   = 2'b10;

  always @(posedge clock) begin
    if (!reset) begin
      settle = 0;
      snap   = {cs, ck};
    end else begin
      if ({cs, ck} != snap) begin
        snap   = {cs, ck};
        settle = 0;
      end
      if (ce && settle < 50) settle++;
    end
    #1;
    if (reset && settle >= 3) begin
      check1("miso",    miso,    m_cs ? 1'b1 : m_tx[m_bit[2:0]]);
      check1("txFull",  txFull,  m_full);
      check8("q",       q,       m_q);
      check1("rxValid", rxValid, m_valid);
      check1("ovr",     ovr,     m_ovr);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks. Every task starts and ends on a negative clock edge.
  // ---------------------------------------------------------------------------
  task automatic wait_ce(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clock);
      if (ce) k++;
    end
    @(negedge clock);
  endtask

  task automatic pulse_load(input logic [7:0] v);
    d      = v;
    txLoad = 1'b1;
    @(posedge clock);
    while (!ce) @(posedge clock);
    if (!m_full) begin
      m_buf  = v;
      m_full = 1'b1;
    end
    @(negedge clock);
    txLoad = 1'b0;
  endtask

  // upd=0 is used when the acknowledge coincides with a byte completion.
  // In that case the model already folded the acknowledge into model_rise.
  task automatic pulse_ack(input bit upd);
    rxAck = 1'b1;
    @(posedge clock);
    while (!ce) @(posedge clock);
    if (upd) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    @(negedge clock);
    rxAck = 1'b0;
  endtask

  task automatic clock_bit(input logic b, input bit ack_same, input bit do_ld,
                           input logic [7:0] ld, output logic got);
    mosi = b;
    wait_ce($urandom_range(4, 6));
    got = miso;                  // master samples miso on its rising edge
    ck  = 1'b1;
    model_rise(b, ack_same);
    if (ack_same) begin
      // The third ce tick after the pin edge is the tick the byte completes.
      wait_ce(2);
      pulse_ack(1'b0);
      wait_ce(2);
    end else begin
      wait_ce($urandom_range(4, 6));
      if (do_ld) begin
        pulse_load(ld);
        wait_ce(2);
      end
    end
    ck = 1'b0;
    model_fall();
  endtask

  task automatic xfer_byte(input logic [7:0] v, input bit ack_same, input bit do_ld,
                           input logic [7:0] ld, output logic [7:0] got);
    logic [7:0] exp;
    logic       b;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(v[i], ack_same && (i == 0), do_ld && (i == 4), ld, b);
      got[i] = b;
    end
    check8("miso_byte", got, exp);
  endtask

  task automatic start_frame();
    cs = 1'b0;
    model_cs_fall();
  endtask

  task automatic end_frame();
    wait_ce($urandom_range(4, 6));
    cs = 1'b1;
    model_cs_rise();
    wait_ce(4);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic report();
    $display("%0d/%0d checks passed", n_pass, n_checks);
  endtask

  initial begin
    logic [7:0] got;
    logic       b;
    int         nb;
    int         nbits;

    // Reset values
    repeat (5) @(negedge clock);
    check1("rst_miso",    miso,    1'b1);
    check1("rst_txFull",  txFull,  1'b0);
    check8("rst_q",       q,       8'h00);
    check1("rst_rxValid", rxValid, 1'b0);
    check1("rst_ovr",     ovr,     1'b0);
    reset = 1'b1;
    wait_ce(4);

    // 1: plain receive of A5 with no reply queued
    start_frame();
    xfer_byte(8'hA5, 1'b0, 1'b0, 8'h00, got);
    end_frame();
    check8("t1_miso_bits", got, 8'hFF);
    check8("t1_q", q, 8'hA5);
    check1("t1_rxValid", rxValid, 1'b1);
    pulse_ack(1'b1);
    wait_ce(3);
    check1("t1_ack_rxValid", rxValid, 1'b0);

    // 2: reply 3C queued before the frame
    pulse_load(8'h3C);
    wait_ce(2);
    check1("t2_txFull_before", txFull, 1'b1);
    start_frame();
    wait_ce(4);
    check1("t2_txFull_after_cs", txFull, 1'b0);
    xfer_byte(8'h00, 1'b0, 1'b0, 8'h00, got);
    end_frame();
    check8("t2_miso_bits", got, 8'h3C);
    check8("t2_q", q, 8'h00);
    pulse_ack(1'b1);
    wait_ce(3);

    // 3: overrun on a second byte, then cleared by an acknowledge
    start_frame();
    xfer_byte(8'h11, 1'b0, 1'b0, 8'h00, got);
    xfer_byte(8'h22, 1'b0, 1'b0, 8'h00, got);
    end_frame();
    check8("t3_q", q, 8'h11);
    check1("t3_ovr", ovr, 1'b1);
    check1("t3_rxValid", rxValid, 1'b1);
    pulse_ack(1'b1);
    wait_ce(3);
    check1("t3_ack_rxValid", rxValid, 1'b0);
    check1("t3_ack_ovr", ovr, 1'b0);

    // 4: aborted partial byte, then a clean 5A
    start_frame();
    for (int i = 0; i < 5; i++) clock_bit(1'b1, 1'b0, 1'b0, 8'h00, b);
    end_frame();
    check1("t4_partial_rxValid", rxValid, 1'b0);
    check1("t4_partial_ovr", ovr, 1'b0);
    start_frame();
    xfer_byte(8'h5A, 1'b0, 1'b0, 8'h00, got);
    end_frame();
    check8("t4_q", q, 8'h5A);
    check1("t4_rxValid", rxValid, 1'b1);
    check1("t4_ovr", ovr, 1'b0);
    check8("t4_miso_bits", got, 8'hFF);
    pulse_ack(1'b1);
    wait_ce(3);

    // 5: second load while full is ignored
    pulse_load(8'h81);
    wait_ce(2);
    pulse_load(8'h7E);
    wait_ce(2);
    check1("t5_txFull", txFull, 1'b1);
    start_frame();
    xfer_byte(8'h00, 1'b0, 1'b0, 8'h00, got);
    end_frame();
    check8("t5_miso_bits", got, 8'h81);
    check1("t5_txFull_after", txFull, 1'b0);
    pulse_ack(1'b1);
    wait_ce(3);

    // Acknowledge on the same tick a byte completes while q is still valid
    start_frame();
    xfer_byte(8'h33, 1'b0, 1'b0, 8'h00, got);
    xfer_byte(8'hC3, 1'b1, 1'b0, 8'h00, got);
    end_frame();
    check8("same_tick_q", q, 8'hC3);
    check1("same_tick_rxValid", rxValid, 1'b1);
    check1("same_tick_ovr", ovr, 1'b0);

    // Mid-byte load is sent as the following byte of the same frame
    pulse_ack(1'b1);
    wait_ce(2);
    start_frame();
    xfer_byte(8'h0F, 1'b0, 1'b1, 8'hE7, got);
    xfer_byte(8'hF0, 1'b0, 1'b0, 8'h00, got);
    end_frame();
    check8("midload_miso_bits", got, 8'hE7);

    // Randomised frames against the model
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        pulse_load(8'($urandom));
        wait_ce(2);
      end
      if ($urandom_range(0, 2) == 0) begin
        pulse_ack(1'b1);
        wait_ce(2);
      end
      start_frame();
      if ($urandom_range(0, 5) == 0) begin
        nbits = $urandom_range(1, 7);
        for (int k = 0; k < nbits; k++)
          clock_bit(1'($urandom), 1'b0, 1'b0, 8'h00, b);
      end else begin
        nb = $urandom_range(1, 3);
        for (int k = 0; k < nb; k++)
          xfer_byte(8'($urandom), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0, 8'($urandom), got);
      end
      end_frame();
    end

    // 6: reset mid-byte with the reply buffer full
    start_frame();
    for (int i = 0; i < 3; i++) clock_bit(1'b0, 1'b0, 1'b0, 8'h00, b);
    wait_ce(4);
    pulse_load(8'h99);
    wait_ce(2);
    check1("t6_txFull_before", txFull, 1'b1);
    reset = 1'b0;
    cs    = 1'b1;
    ck    = 1'b0;
    #1;
    check1("t6_miso",    miso,    1'b1);
    check1("t6_txFull",  txFull,  1'b0);
    check8("t6_q",       q,       8'h00);
    check1("t6_rxValid", rxValid, 1'b0);
    check1("t6_ovr",     ovr,     1'b0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    wait_ce(4);
    start_frame();
    xfer_byte(8'h96, 1'b0, 1'b0, 8'h00, got);
    end_frame();
    check8("t6_post_q", q, 8'h96);
    check8("t6_post_miso_bits", got, 8'hFF);

    report();
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: bench did not complete by %0t", $time);
    n_checks++;
    report();
    $finish;
  end

endmodule
